// File: rtl/a3213_pkg.sv
// -----------------------------------------------------------------------------
// a3213_pkg
// Shared constants for the input conditioning front end.
//   NUM_SW           number of board slide switches (sw1..sw4)
//   NUM_CHAN         debounced channels: switches + write button + auto switch
//   DEBOUNCE_DEFAULT stable cycles needed before a new level is accepted (5 ms)
//   SYSCLK_HZ        system clock frequency the default debounce time assumes
// -----------------------------------------------------------------------------
package a3213_pkg;

  localparam int NUM_SW           = 4;
  localparam int NUM_CHAN         = NUM_SW + 2;
  localparam int DEBOUNCE_DEFAULT = 250000;
  localparam int SYSCLK_HZ        = 50_000_000;

  // Channel positions inside the packed raw/level vectors of the top level.
  localparam int CH_WRITE = NUM_SW;
  localparam int CH_AUTO  = NUM_SW + 1;

endpackage : a3213_pkg

// File: rtl/debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
// One input channel: 2-flop synchroniser followed by a counter-based debouncer.
// A new level is accepted only after the synchronised input has differed from
// the current stable level for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   sysclk  in  1  system clock (rising edge)
//   reset   in  1  synchronous, active-high reset
//   raw     in  1  asynchronous raw input
//   level   out 1  debounced level (the stable register itself)
// -----------------------------------------------------------------------------
module debounce_chan #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic sysclk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
      if (r_s2 == r_stable) begin
        // Any return to the stable level throws away the partial count.
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        // Cannot pass CNT_LAST: the branch above always catches it first.
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_stable;

endmodule : debounce_chan

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Front end for the control block: debounces sw1..sw4, write and auto, and
// produces single-cycle write press/release pulses plus a switch word captured
// at every write press.
// Ports:
//   sysclk       in  1  system clock, all flops on its rising edge
//   reset        in  1  synchronous, active-high reset
//   sw_raw       in  4  raw switches (bit0 = sw1)
//   write_raw    in  1  raw write pushbutton, active-high
//   auto_raw     in  1  raw auto-mode switch
//   sw           out 4  debounced switch levels
//   sw_latched   out 4  debounced sw captured when write_pulse asserts
//   write_lvl    out 1  debounced write level
//   write_pulse  out 1  one-cycle pulse, cycle after write_lvl rises
//   write_rel    out 1  one-cycle pulse, cycle after write_lvl falls
//   auto_lvl     out 1  debounced auto level
// -----------------------------------------------------------------------------
module input_conditioner
  import a3213_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 18
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw_raw,
  input  logic              write_raw,
  input  logic              auto_raw,
  output logic [NUM_SW-1:0] sw,
  output logic [NUM_SW-1:0] sw_latched,
  output logic              write_lvl,
  output logic              write_pulse,
  output logic              write_rel,
  output logic              auto_lvl
);

  logic [NUM_CHAN-1:0] w_raw;
  logic [NUM_CHAN-1:0] w_level;
  logic                w_write_rise;
  logic                w_write_fall;

  logic                r_write_prev;
  logic                r_write_pulse;
  logic                r_write_rel;
  logic [NUM_SW-1:0]   r_sw_latched;

  assign w_raw = {auto_raw, write_raw, sw_raw};

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .sysclk (sysclk),
      .reset  (reset),
      .raw    (w_raw[g]),
      .level  (w_level[g])
    );
  end

  // r_write_prev trails the stable write level by one cycle, so a difference
  // between the two marks the cycle right after an accepted change.
  assign w_write_rise =  w_level[CH_WRITE] & ~r_write_prev;
  assign w_write_fall = ~w_level[CH_WRITE] &  r_write_prev;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_write_prev  <= 1'b0;
      r_write_pulse <= 1'b0;
      r_write_rel   <= 1'b0;
      r_sw_latched  <= '0;
    end else begin
      r_write_prev  <= w_level[CH_WRITE];
      r_write_pulse <= w_write_rise;
      r_write_rel   <= w_write_fall;
      // Captured together with the pulse rising, from the debounced switches,
      // so a switch accepted on the same edge as the press is included.
      if (w_write_rise) begin
        r_sw_latched <= w_level[NUM_SW-1:0];
      end
    end
  end

  assign sw          = w_level[NUM_SW-1:0];
  assign write_lvl   = w_level[CH_WRITE];
  assign auto_lvl    = w_level[CH_AUTO];
  assign write_pulse = r_write_pulse;
  assign write_rel   = r_write_rel;
  assign sw_latched  = r_sw_latched;

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
// Directed bench for input_conditioner with DEBOUNCE_CYCLES = 8. Inputs change
// on the falling edge; outputs are checked 1 ns after each rising edge against
// a window-based model, and at falling edges against hand-computed values.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int DB    = 8;
  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw_raw = 4'hF;
  logic       write_raw = 1'b1;
  logic       auto_raw = 1'b1;

  logic [3:0] sw;
  logic [3:0] sw_latched;
  logic       write_lvl;
  logic       write_pulse;
  logic       write_rel;
  logic       auto_lvl;

  always #10 clk = ~clk;

  input_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (CNT_W)
  ) dut (
    .sysclk      (clk),
    .reset       (reset),
    .sw_raw      (sw_raw),
    .write_raw   (write_raw),
    .auto_raw    (auto_raw),
    .sw          (sw),
    .sw_latched  (sw_latched),
    .write_lvl   (write_lvl),
    .write_pulse (write_pulse),
    .write_rel   (write_rel),
    .auto_lvl    (auto_lvl)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Channel vector layout: [3:0] sw, [4] write, [5] auto.
  // A channel accepts a new level when the last DB synchronised samples since
  // reset all disagree with its current level; the synchronised sample seen at
  // an edge is the raw value captured two edges earlier (0 right after reset).
  logic [5:0] m_raw_q[$];
  logic [5:0] m_sync_q[$];
  logic [5:0] m_stable  = '0;
  logic       m_rise_d  = 1'b0;
  logic       m_fall_d  = 1'b0;
  logic       m_pulse   = 1'b0;
  logic       m_rel     = 1'b0;
  logic [3:0] m_latched = '0;

  always @(posedge clk) begin
    logic [5:0] raw_now;
    logic [5:0] sync_now;
    logic [5:0] old_st;
    logic [5:0] new_st;
    raw_now = {auto_raw, write_raw, sw_raw};
    if (reset) begin
      m_raw_q.delete();
      m_sync_q.delete();
      m_stable  = '0;
      m_rise_d  = 1'b0;
      m_fall_d  = 1'b0;
      m_pulse   = 1'b0;
      m_rel     = 1'b0;
      m_latched = '0;
    end else begin
      sync_now = (m_raw_q.size() >= 2) ? m_raw_q[m_raw_q.size()-2] : 6'b0;
      m_raw_q.push_back(raw_now);
      if (m_raw_q.size() > 2) void'(m_raw_q.pop_front());
      m_sync_q.push_back(sync_now);
      if (m_sync_q.size() > DB) void'(m_sync_q.pop_front());
      old_st = m_stable;
      new_st = old_st;
      if (m_sync_q.size() == DB) begin
        for (int c = 0; c < 6; c++) begin
          int disagree;
          disagree = 0;
          for (int k = 0; k < DB; k++)
            if (m_sync_q[k][c] != old_st[c]) disagree++;
          if (disagree == DB) new_st[c] = ~old_st[c];
        end
      end
      // Pulses report the change accepted on the previous edge.
      m_pulse = m_rise_d;
      m_rel   = m_fall_d;
      if (m_pulse) m_latched = old_st[3:0];
      m_rise_d = new_st[4] & ~old_st[4];
      m_fall_d = ~new_st[4] & old_st[4];
      m_stable = new_st;
    end
    #1;
    check("model_sw",          32'(sw),          32'(m_stable[3:0]));
    check("model_write_lvl",   32'(write_lvl),   32'(m_stable[4]));
    check("model_auto_lvl",    32'(auto_lvl),    32'(m_stable[5]));
    check("model_write_pulse", 32'(write_pulse), 32'(m_pulse));
    check("model_write_rel",   32'(write_rel),   32'(m_rel));
    check("model_sw_latched",  32'(sw_latched),  32'(m_latched));
    check("pulse_rel_exclusive", 32'(write_pulse & write_rel), 32'(0));
  end

  // ---------------- driver helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sw"},          32'(sw),          32'(0));
    check({tag, "_sw_latched"},  32'(sw_latched),  32'(0));
    check({tag, "_write_lvl"},   32'(write_lvl),   32'(0));
    check({tag, "_write_pulse"}, 32'(write_pulse), 32'(0));
    check({tag, "_write_rel"},   32'(write_rel),   32'(0));
    check({tag, "_auto_lvl"},    32'(auto_lvl),    32'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // 1: reset with all raw inputs high
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_all_zero("t1_reset");
    end
    reset = 1'b0;
    step(9);
    check("t1_sw_at9", 32'(sw), 32'(0));
    step(1);
    check("t1_sw_at10",        32'(sw),          32'hF);
    check("t1_write_lvl_at10", 32'(write_lvl),   32'(1));
    check("t1_auto_lvl_at10",  32'(auto_lvl),    32'(1));
    check("t1_pulse_at10",     32'(write_pulse), 32'(0));
    step(1);
    check("t1_pulse_at11",     32'(write_pulse), 32'(1));
    check("t1_latched_at11",   32'(sw_latched),  32'hF);
    step(1);
    check("t1_pulse_at12",     32'(write_pulse), 32'(0));

    // settle everything low
    sw_raw = 4'h0; write_raw = 1'b0; auto_raw = 1'b0;
    step(20);
    check("settle_sw",        32'(sw),         32'(0));
    check("settle_write_lvl", 32'(write_lvl),  32'(0));
    check("settle_latched",   32'(sw_latched), 32'hF);

    // 2: clean switch step
    sw_raw = 4'h1;
    step(9);
    check("t2_sw_at9", 32'(sw), 32'h0);
    step(1);
    check("t2_sw_at10", 32'(sw), 32'h1);

    // 3: bouncing write, then a clean hold
    for (int seg = 0; seg < 10; seg++) begin
      write_raw = (seg % 2 == 0);
      for (int k = 0; k < 3; k++) begin
        step(1);
        check("t3_bounce_lvl",   32'(write_lvl),   32'(0));
        check("t3_bounce_pulse", 32'(write_pulse), 32'(0));
      end
    end
    write_raw = 1'b1;
    step(10);
    check("t3_lvl_at10",   32'(write_lvl),   32'(1));
    check("t3_pulse_at10", 32'(write_pulse), 32'(0));
    step(1);
    check("t3_pulse_at11",   32'(write_pulse), 32'(1));
    check("t3_latched_at11", 32'(sw_latched),  32'h1);
    step(1);
    check("t3_pulse_at12", 32'(write_pulse), 32'(0));
    write_raw = 1'b0;
    step(20);

    // switch change accepted on the same edge as the write press
    sw_raw = 4'h3; write_raw = 1'b1;
    step(11);
    check("simul_pulse",   32'(write_pulse), 32'(1));
    check("simul_latched", 32'(sw_latched),  32'h3);
    write_raw = 1'b0;
    step(15);

    // 4: press with sw=5, change sw during the hold, release
    sw_raw = 4'h5;
    step(15);
    write_raw = 1'b1;
    step(11);
    check("t4_pulse",   32'(write_pulse), 32'(1));
    check("t4_latched", 32'(sw_latched),  32'h5);
    step(1);
    check("t4_pulse_width", 32'(write_pulse), 32'(0));
    sw_raw = 4'hA;
    step(8);
    check("t4_latched_hold", 32'(sw_latched), 32'h5);
    write_raw = 1'b0;
    step(10);
    check("t4_lvl_released", 32'(write_lvl), 32'(0));
    check("t4_rel_at10",     32'(write_rel), 32'(0));
    step(1);
    check("t4_rel_at11", 32'(write_rel), 32'(1));
    step(1);
    check("t4_rel_at12",         32'(write_rel),  32'(0));
    check("t4_latched_after",    32'(sw_latched), 32'h5);
    check("t4_sw_changed",       32'(sw),         32'hA);

    // 6: short write glitch is rejected
    write_raw = 1'b1;
    step(6);
    write_raw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("t6_lvl",   32'(write_lvl),   32'(0));
      check("t6_pulse", 32'(write_pulse), 32'(0));
    end
    check("t6_latched", 32'(sw_latched), 32'h5);

    // 5: reset in the middle of a count restarts it
    auto_raw = 1'b1;
    step(7);
    check("t5_auto_mid_count", 32'(auto_lvl), 32'(0));
    reset = 1'b1;
    step(1);
    check_all_zero("t5_reset_a");
    step(1);
    check_all_zero("t5_reset_b");
    reset = 1'b0;
    step(9);
    check("t5_auto_at9", 32'(auto_lvl), 32'(0));
    step(1);
    check("t5_auto_at10",  32'(auto_lvl),  32'(1));
    check("t5_sw_at10",    32'(sw),        32'hA);
    check("t5_write_at10", 32'(write_lvl), 32'(0));
    step(2);
    check("t5_no_pulse", 32'(write_pulse), 32'(0));
    check("t5_latched",  32'(sw_latched),  32'h0);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_input_conditioner
